// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding and enable-decoding helpers for the
// multiplexed seven-segment scan decoder.
package seg_pkg;

    // Active-low segment patterns on bits a..g (bit0 = a, bit6 = g)
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] ERR_NIBBLE   = 4'hF;
    localparam logic [3:0] BLANK_NIBBLE = 4'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } scan_state_t;

    // Exactly one low bit in an active-low enable vector padded to 8 bits
    function automatic logic low_is_onehot(input logic [7:0] en);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, ~en[i]};
        end
        return (n == 4'd1);
    endfunction

    // Position of the lowest low bit; only meaningful when low_is_onehot holds
    function automatic logic [2:0] low_index(input logic [7:0] en);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!en[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scan-input and captured-digit bus of the seven-segment scan decoder.
interface seg_scan_decoder_if #(
    parameter int NDIG = 6
);
    logic [7:0]        seg_in;
    logic [NDIG-1:0]   dig_en;
    logic [4*NDIG-1:0] digits_out;
    logic [NDIG-1:0]   blank_out;
    logic [NDIG-1:0]   err_out;
    logic              upd_valid;
    logic [2:0]        upd_idx;

    modport master (
        output seg_in, dig_en,
        input  digits_out, blank_out, err_out, upd_valid, upd_idx
    );

    modport slave (
        input  seg_in, dig_en,
        output digits_out, blank_out, err_out, upd_valid, upd_idx
    );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational lookup of an active-low segment pattern to digit/blank/err;
// the decimal point is not part of the pattern.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] value,
    output logic       blank,
    output logic       err
);

    logic unused_dp_s;
    assign unused_dp_s = seg[7];

    // Pattern lookup; anything not in the table is an error capture
    always_comb begin
        value = ERR_NIBBLE;
        blank = 1'b0;
        err   = 1'b0;
        case (seg[6:0])
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: begin
                value = BLANK_NIBBLE;
                blank = 1'b1;
            end
            default: begin
                value = ERR_NIBBLE;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-position digits from a multiplexed seven-segment scan by
// capturing each position once its pattern has been stable for STABLE_CYC samples.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG       = 6,
    parameter int STABLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_decoder_if.slave bus
);

    localparam int         SW         = 7 + NDIG;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYC);

    logic [7:0]        seg_s1_r, seg_s2_r;
    logic [NDIG-1:0]   dig_s1_r, dig_s2_r;
    logic [SW-1:0]     sample_s, prev_r;
    logic [7:0]        en_pad_s;
    logic              onehot_s, same_s;
    logic [2:0]        idx_s;
    scan_state_t       state_r, state_s;
    logic [7:0]        cnt_r, cnt_s;
    logic              commit_s;
    logic [3:0]        dec_value_s;
    logic              dec_blank_s, dec_err_s;
    logic [4*NDIG-1:0] digits_r;
    logic [NDIG-1:0]   blank_r, err_r;
    logic              upd_valid_r;
    logic [2:0]        upd_idx_r;

    seg_pattern_decode u_decode (
        .seg   (seg_s2_r),
        .value (dec_value_s),
        .blank (dec_blank_s),
        .err   (dec_err_s)
    );

    // Two-flop synchronizer on the asynchronous scan inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s1_r <= 8'hFF;
            seg_s2_r <= 8'hFF;
            dig_s1_r <= {NDIG{1'b1}};
            dig_s2_r <= {NDIG{1'b1}};
        end else begin
            seg_s1_r <= bus.seg_in;
            seg_s2_r <= seg_s1_r;
            dig_s1_r <= bus.dig_en;
            dig_s2_r <= dig_s1_r;
        end
    end

    // Sample comparison and enable decoding (unused upper enable bits read as off)
    always_comb begin
        en_pad_s = 8'hFF;
        for (int i = 0; i < NDIG; i++) begin
            en_pad_s[i] = dig_s2_r[i];
        end
        sample_s = {seg_s2_r[6:0], dig_s2_r};
        same_s   = (sample_s == prev_r);
        onehot_s = low_is_onehot(en_pad_s);
        idx_s    = low_index(en_pad_s);
    end

    // FSM state, stability counter and previous-sample register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            prev_r  <= {SW{1'b1}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            prev_r  <= sample_s;
        end
    end

    // Next-state logic; the counter saturates so a commit fires only once
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        commit_s = 1'b0;
        if (!onehot_s) begin
            state_s = IDLE;
            cnt_s   = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = TRACK;
                    cnt_s   = 8'd1;
                end
                TRACK: begin
                    if (same_s) begin
                        if (cnt_r >= STABLE_MAX) begin
                            cnt_s = STABLE_MAX;
                        end else begin
                            cnt_s = cnt_r + 8'd1;
                        end
                        if (cnt_s == STABLE_MAX) begin
                            commit_s = 1'b1;
                            state_s  = HELD;
                        end else begin
                            commit_s = 1'b0;
                        end
                    end else begin
                        cnt_s = 8'd1;
                    end
                end
                HELD: begin
                    if (same_s) begin
                        cnt_s = cnt_r;
                    end else begin
                        state_s = TRACK;
                        cnt_s   = 8'd1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = 8'd0;
                end
            endcase
        end
    end

    // Held per-position results; only the committed position is rewritten
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_r    <= {(4*NDIG){1'b0}};
            blank_r     <= {NDIG{1'b1}};
            err_r       <= {NDIG{1'b0}};
            upd_valid_r <= 1'b0;
            upd_idx_r   <= 3'd0;
        end else begin
            upd_valid_r <= commit_s;
            if (commit_s) begin
                upd_idx_r <= idx_s;
                for (int k = 0; k < NDIG; k++) begin
                    if (idx_s == 3'(k)) begin
                        digits_r[4*k +: 4] <= dec_value_s;
                        blank_r[k]         <= dec_blank_s;
                        err_r[k]           <= dec_err_s;
                    end
                end
            end else begin
                upd_idx_r <= upd_idx_r;
            end
        end
    end

    assign bus.digits_out = digits_r;
    assign bus.blank_out  = blank_r;
    assign bus.err_out    = err_r;
    assign bus.upd_valid  = upd_valid_r;
    assign bus.upd_idx    = upd_idx_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed, table-driven bench for seg_scan_decoder (NDIG=6, STABLE_CYC=16).
module tb_seg_scan_decoder;
    import seg_pkg::*;

    localparam int NDIG       = 6;
    localparam int STABLE_CYC = 16;
    localparam int LAT        = 2 + STABLE_CYC;
    localparam int NVEC       = 14;

    typedef struct {
        logic [7:0]      seg;
        logic [NDIG-1:0] dig;
        logic [2:0]      idx;
        logic [3:0]      nib;
        logic            blank;
        logic            err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    vec_t              vecs [NVEC];
    logic [4*NDIG-1:0] exp_digits;
    logic [NDIG-1:0]   exp_blank;
    logic [NDIG-1:0]   exp_err;

    seg_scan_decoder_if #(.NDIG(NDIG)) bus ();

    seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one pattern for ncyc cycles, counting strobes and noting the first one
    task automatic apply_slot(input logic [7:0] seg, input logic [NDIG-1:0] dig, input int ncyc,
                              output int strobes, output int first, output logic [2:0] idx);
        @(posedge clk);
        #1;
        bus.seg_in = seg;
        bus.dig_en = dig;
        strobes = 0;
        first   = -1;
        idx     = 3'd0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (bus.upd_valid === 1'b1) begin
                strobes++;
                if (first < 0) begin
                    first = c;
                    idx   = bus.upd_idx;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_digits"}, 32'(bus.digits_out), 32'(exp_digits));
        check({tag, "_blank"},  32'(bus.blank_out),  32'(exp_blank));
        check({tag, "_err"},    32'(bus.err_out),    32'(exp_err));
    endtask

    task automatic model_reset();
        exp_digits = {(4*NDIG){1'b0}};
        exp_blank  = {NDIG{1'b1}};
        exp_err    = {NDIG{1'b0}};
    endtask

    initial begin
        int         s1, s2, f1, f2;
        logic [2:0] i1, i2;
        logic [7:0] scan_seg [NDIG];

        vecs[0]  = '{8'hB0, 6'b111110, 3'd0, 4'h3, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 6'b101111, 3'd4, 4'h0, 1'b1, 1'b0};
        vecs[2]  = '{8'h7E, 6'b011111, 3'd5, 4'hF, 1'b0, 1'b1};
        vecs[3]  = '{8'h40, 6'b111101, 3'd1, 4'h0, 1'b0, 1'b0};
        vecs[4]  = '{8'h79, 6'b111011, 3'd2, 4'h1, 1'b0, 1'b0};
        vecs[5]  = '{8'hA4, 6'b110111, 3'd3, 4'h2, 1'b0, 1'b0};
        vecs[6]  = '{8'h19, 6'b111110, 3'd0, 4'h4, 1'b0, 1'b0};
        vecs[7]  = '{8'h12, 6'b101111, 3'd4, 4'h5, 1'b0, 1'b0};
        vecs[8]  = '{8'h02, 6'b011111, 3'd5, 4'h6, 1'b0, 1'b0};
        vecs[9]  = '{8'h78, 6'b111101, 3'd1, 4'h7, 1'b0, 1'b0};
        vecs[10] = '{8'h00, 6'b111011, 3'd2, 4'h8, 1'b0, 1'b0};
        vecs[11] = '{8'h10, 6'b110111, 3'd3, 4'h9, 1'b0, 1'b0};
        vecs[12] = '{8'h7F, 6'b111110, 3'd0, 4'h0, 1'b1, 1'b0};
        vecs[13] = '{8'h41, 6'b111101, 3'd1, 4'hF, 1'b0, 1'b1};

        scan_seg[0] = 8'hC0;
        scan_seg[1] = 8'h80;
        scan_seg[2] = 8'hC0;
        scan_seg[3] = 8'h80;
        scan_seg[4] = 8'hB0;
        scan_seg[5] = 8'h90;

        bus.seg_in = 8'hFF;
        bus.dig_en = {NDIG{1'b1}};
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs("reset");
        check("reset_upd_valid", 32'(bus.upd_valid), 32'd0);
        check("reset_upd_idx",   32'(bus.upd_idx),   32'd0);

        // Two enables low: never a valid slot
        apply_slot(8'h80, 6'b111100, 40, s1, f1, i1);
        check("twolow_strobes", 32'(s1), 32'd0);
        check_outputs("twolow");

        for (int v = 0; v < NVEC; v++) begin
            apply_slot(vecs[v].seg, vecs[v].dig, 24, s1, f1, i1);
            exp_digits[int'(vecs[v].idx)*4 +: 4] = vecs[v].nib;
            exp_blank[vecs[v].idx]              = vecs[v].blank;
            exp_err[vecs[v].idx]                = vecs[v].err;
            check($sformatf("vec%0d_strobes", v), 32'(s1), 32'd1);
            check($sformatf("vec%0d_latency", v), 32'(f1), 32'(LAT));
            check($sformatf("vec%0d_idx", v),     32'(i1), 32'(vecs[v].idx));
            check_outputs($sformatf("vec%0d", v));
        end

        // Short-lived pattern must not be captured; the follow-on one must
        apply_slot(8'h92, 6'b111011, 10, s1, f1, i1);
        apply_slot(8'h90, 6'b111011, 24, s2, f2, i2);
        exp_digits[11:8] = 4'h9;
        check("short_strobes",  32'(s1 + s2), 32'd1);
        check("short_latency",  32'(f2),      32'(LAT));
        check("short_idx",      32'(i2),      32'd2);
        check_outputs("short");

        // Reset while the counter sits at 15 discards the pending capture
        apply_slot(8'hC0, 6'b111110, 17, s1, f1, i1);
        check("rstmid_pre_strobes", 32'(s1), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        s1 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.upd_valid === 1'b1) s1++;
        end
        check("rstmid_strobes", 32'(s1), 32'd0);
        check("rstmid_upd_idx", 32'(bus.upd_idx), 32'd0);
        check_outputs("rstmid");
        apply_slot(8'hFF, {NDIG{1'b1}}, 4, s1, f1, i1);

        // Full scan of all positions
        for (int k = 0; k < NDIG; k++) begin
            apply_slot(scan_seg[k], ~(6'(1) << k), 32, s1, f1, i1);
            check($sformatf("scan%0d_strobes", k), 32'(s1), 32'd1);
            check($sformatf("scan%0d_idx", k),     32'(i1), 32'(k));
        end
        exp_digits = 24'h938080;
        exp_blank  = {NDIG{1'b0}};
        exp_err    = {NDIG{1'b0}};
        check_outputs("scan");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
